// File: rtl/mem_if_pkg.sv
// Shared definitions for the RAM access path: FSM state encoding, transfer op and default widths.
package mem_if_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the ACCESS phase; tc flags the last strobe cycle.
module mem_wait_counter
  import mem_if_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/mem_access_controller.sv
// CPU-side initiator for the asynchronous RAM: owns MAR/MDR and sequences each transfer
// as SETUP -> ACCESS (strobe) -> HOLD so address and data never move under a strobe.
module mem_access_controller
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              start_read,
  input  logic              start_write,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              req_err,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] Mdatain
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t            state;
  op_t               op;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              cnt_load;
  logic              cnt_en;
  logic              last_access;

  // Counter is armed during SETUP so it already holds WAIT_CYCLES on the first ACCESS cycle.
  assign cnt_load = (state == SETUP);
  assign cnt_en   = (state == ACCESS);

  mem_wait_counter #(.W(CNT_W)) u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (WAIT_LOAD),
    .tc       (last_access)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      op      <= OP_READ;
      mar     <= '0;
      mdr     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      req_err <= 1'b0;
      read    <= 1'b0;
      write   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the case arms,
      // so each flag is a clean one-cycle pulse unless a state explicitly re-asserts it.
      req_err <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr <= BusMuxOut;
          if (start_read && start_write) begin
            req_err <= 1'b1;
          end else if (start_read || start_write) begin
            op    <= start_read ? OP_READ : OP_WRITE;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          read  <= (op == OP_READ);
          write <= (op == OP_WRITE);
          state <= ACCESS;
        end
        ACCESS: begin
          if (last_access) begin
            if (op == OP_READ) mdr <= Mdatain;
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdr_out   = mdr;
  assign address   = mar;
  assign ram_wdata = mdr;

endmodule

// File: tb/tb_mem_access_controller.sv
// Scoreboard bench: stimulus pushes expected transfer results; a monitor pops and checks on done.
module tb_mem_access_controller;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int W  = 1;

  typedef struct {
    bit            is_read;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] BusMuxOut = '0;
  logic          MARin = 1'b0;
  logic          MDRin = 1'b0;
  logic          start_read = 1'b0;
  logic          start_write = 1'b0;
  logic [DW-1:0] mdr_out;
  logic          busy, done, req_err, read, write;
  logic [AW-1:0] address;
  logic [DW-1:0] ram_wdata;
  wire  [DW-1:0] Mdatain;

  logic [DW-1:0] mem [512];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mem_access_controller #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .start_read  (start_read),
    .start_write (start_write),
    .mdr_out     (mdr_out),
    .busy        (busy),
    .done        (done),
    .req_err     (req_err),
    .read        (read),
    .write       (write),
    .address     (address),
    .ram_wdata   (ram_wdata),
    .Mdatain     (Mdatain)
  );

  always #5 clock = ~clock;

  // Asynchronous RAM model: level-sensitive write, tri-stated read port.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0BAD_F00D;
    mem[2] = 32'hCAFE_0002;
    forever begin
      @(write or address or ram_wdata);
      if (write) mem[address] = ram_wdata;
    end
  end
  assign Mdatain = read ? mem[address] : 'z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe safety and scoreboard comparison on every done pulse.
  logic          prev_busy = 1'b0;
  logic          cur_wr = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wd;
  int            strobe_cnt = 0;
  int            stab_err = 0;
  int            overlap = 0;
  exp_t          e;

  always @(negedge clock or negedge clear) begin
    if (!clear) begin
      prev_busy  = 1'b0;
      cur_wr     = 1'b0;
      strobe_cnt = 0;
      stab_err   = 0;
    end else begin
      if (read && write) overlap++;
      if (read || write) strobe_cnt++;
      if (write) cur_wr = 1'b1;
      if (busy) begin
        if (!prev_busy) begin
          hold_addr = address;
          hold_wd   = ram_wdata;
        end else begin
          if (address !== hold_addr) stab_err++;
          if ((!done || cur_wr) && ram_wdata !== hold_wd) stab_err++;
        end
      end
      if (done) begin
        check("sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_addr", 64'(address), 64'(e.addr));
          if (e.is_read) check("read_data", 64'(mdr_out), 64'(e.data));
          else           check("write_mem", 64'(mem[e.addr]), 64'(e.data));
          check("strobe_len", 64'(strobe_cnt), 64'(W + 1));
          check("addr_data_stable", 64'(stab_err), 64'd0);
        end
        strobe_cnt = 0;
        stab_err   = 0;
        cur_wr     = 1'b0;
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_mar(input logic [DW-1:0] v);
    BusMuxOut = v; MARin = 1'b1; tick(); MARin = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    BusMuxOut = v; MDRin = 1'b1; tick(); MDRin = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic start_op(input bit is_read);
    if (is_read) start_read = 1'b1;
    else         start_write = 1'b1;
    tick();
    start_read  = 1'b0;
    start_write = 1'b0;
  endtask

  task automatic do_xfer(input bit is_read, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back('{is_read: is_read, addr: a, data: d});
    start_op(is_read);
    wait_idle(is_read ? "read" : "write");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 clear = 1'b1;
    @(negedge clock);
    check("reset_state", 64'({busy, done, req_err, read, write, address, mdr_out}), 64'd0);

    // Write then read back through a cleared MDR.
    load_mar(32'h0000_01F5);
    load_mdr(32'hDEAD_BEEF);
    do_xfer(1'b0, 9'h1F5, 32'hDEAD_BEEF);
    load_mdr(32'h0000_0000);
    do_xfer(1'b1, 9'h1F5, 32'hDEAD_BEEF);

    // MAR keeps only the low address bits.
    load_mar(32'h0000_0A02);
    check("addr_truncate", 64'(address), 64'h002);
    do_xfer(1'b1, 9'h002, 32'hCAFE_0002);

    // Both starts together: error pulse only.
    start_read = 1'b1; start_write = 1'b1;
    tick();
    start_read = 1'b0; start_write = 1'b0;
    check("dbl_req_err", 64'(req_err), 64'd1);
    check("dbl_busy", 64'({busy, read, write}), 64'd0);
    tick();
    check("dbl_req_err_pulse", 64'(req_err), 64'd0);
    check("dbl_no_start", 64'({busy, read, write}), 64'd0);

    // Reset during the strobe of a write.
    load_mar(32'h0000_0010);
    load_mdr(32'h1234_5678);
    start_op(1'b0);
    for (int n = 0; n < 10 && !write; n++) tick();
    check("abort_strobe_seen", 64'(write), 64'd1);
    #1 clear = 1'b0;
    #1 check("abort_async", 64'({busy, done, read, write, address, mdr_out}), 64'd0);
    #1 clear = 1'b1;
    tick();
    do_xfer(1'b1, 9'h000, 32'h0BAD_F00D);

    // MARin during a transfer is ignored until IDLE.
    load_mar(32'h0000_01F5);
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    sb.push_back('{is_read: 1'b1, addr: 9'h1F5, data: 32'hDEAD_BEEF});
    tick();
    BusMuxOut = 32'h0000_0055;
    MARin = 1'b1;
    wait_idle("busy_ignore");
    check("mar_frozen", 64'(address), 64'h1F5);
    tick();
    MARin = 1'b0;
    check("mar_after_idle", 64'(address), 64'h055);

    tick();
    check("no_overlap", 64'(overlap), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
